// File: rtl/key_loader_pkg.sv
// Shared types and defaults for the serial key loader.
// Optional feature macro: KEY_LOADER_LOCKOUT_EN (fail counter + LOCKOUT state).
package key_loader_pkg;

   localparam int unsigned DEF_KEY_W    = 14;
   localparam int unsigned DEF_CHK_W    = 4;
   localparam int unsigned DEF_MAX_FAIL = 3;
   localparam int unsigned STATE_W      = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_CHECK   = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_ERROR   = 3'd4,
      ST_LOCKOUT = 3'd5
   } state_e;

   // XOR-fold of a default-width key: bin j collects bits i with i mod CHK_W = j
   function automatic logic [0:DEF_CHK_W-1] chk_fold(input logic [0:DEF_KEY_W-1] key);
      logic [0:DEF_CHK_W-1] r;
      r = '0;
      for (int unsigned i = 0; i < DEF_KEY_W; i++) begin
         r[i % DEF_CHK_W] = r[i % DEF_CHK_W] ^ key[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/key_chk_fold.sv
// Combinational XOR-fold checksum of a key; unequal bin sizes when KEY_W mod CHK_W != 0.
module key_chk_fold
   import key_loader_pkg::*;
#(
   parameter int unsigned KEY_W = DEF_KEY_W,
   parameter int unsigned CHK_W = DEF_CHK_W
) (
   input  logic [0:KEY_W-1] key,
   output logic [0:CHK_W-1] chk
);

   // fold key bits into CHK_W parity bins
   always_comb begin
      chk = '0;
      for (int unsigned i = 0; i < KEY_W; i++) begin
         chk[i % CHK_W] = chk[i % CHK_W] ^ key[i];
      end
   end

endmodule

// File: rtl/key_loader.sv
// Bit-serial key loader: shifts in key + checksum, verifies the XOR-fold and
// presents the key on k only after a successful check.
// Optional feature macro: KEY_LOADER_LOCKOUT_EN (lockout after MAX_FAIL bad loads).
module key_loader
   import key_loader_pkg::*;
#(
   parameter int unsigned KEY_W    = DEF_KEY_W,
   parameter int unsigned CHK_W    = DEF_CHK_W,
   parameter int unsigned MAX_FAIL = DEF_MAX_FAIL
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             sdi,
   input  logic             sdi_valid,
   input  logic             clr,
   output logic [0:KEY_W-1] k,
   output logic             key_ready,
   output logic             key_err,
   output logic             busy
);

   localparam int unsigned SR_W  = KEY_W + CHK_W;
   localparam int unsigned CNT_W = $clog2(SR_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SR_W - 1);

   localparam logic [STATE_W-1:0] IDLE    = ST_IDLE;
   localparam logic [STATE_W-1:0] SHIFT   = ST_SHIFT;
   localparam logic [STATE_W-1:0] CHECK   = ST_CHECK;
   localparam logic [STATE_W-1:0] LOCKED  = ST_LOCKED;
   localparam logic [STATE_W-1:0] ERROR   = ST_ERROR;

   if (CHK_W < 1 || CHK_W > KEY_W || MAX_FAIL < 1) begin : g_param_chk
      $error("key_loader: illegal KEY_W/CHK_W/MAX_FAIL");
   end

   logic [STATE_W-1:0] state, state_nx;
   logic [0:SR_W-1]    sr, sr_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [0:KEY_W-1]   k_nx;
   logic               ready_nx;
   logic               err_nx;
   logic [0:CHK_W-1]   chk_exp;
   logic               chk_ok;
   logic               clr_eff;

`ifdef KEY_LOADER_LOCKOUT_EN
   localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
   localparam logic [STATE_W-1:0] LOCKOUT = ST_LOCKOUT;

   logic [FAIL_W-1:0] fail, fail_nx;

   assign clr_eff = clr && (state != LOCKOUT);
`else
   assign clr_eff = clr;
`endif

   key_chk_fold #(
      .KEY_W (KEY_W),
      .CHK_W (CHK_W)
   ) u_fold (
      .key (sr[0:KEY_W-1]),
      .chk (chk_exp)
   );

   assign chk_ok = (chk_exp == sr[KEY_W +: CHK_W]);
   assign busy   = (state == SHIFT) || (state == CHECK);

   // next-state and next-register logic; clr overrides everything but LOCKOUT
   always_comb begin
      state_nx = state;
      sr_nx    = sr;
      cnt_nx   = cnt;
      k_nx     = k;
      ready_nx = key_ready;
      err_nx   = key_err;
`ifdef KEY_LOADER_LOCKOUT_EN
      fail_nx  = fail;
`endif
      case (state)
         IDLE: begin
            if (sdi_valid) begin
               sr_nx    = '0;
               sr_nx[0] = sdi;
               cnt_nx   = CNT_W'(1);
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (sdi_valid) begin
               sr_nx[cnt] = sdi;
               cnt_nx     = cnt + CNT_W'(1);
               if (cnt == LAST) state_nx = CHECK;
            end
         end
         CHECK: begin
            if (chk_ok) begin
               k_nx     = sr[0:KEY_W-1];
               ready_nx = 1'b1;
               state_nx = LOCKED;
`ifdef KEY_LOADER_LOCKOUT_EN
               fail_nx  = '0;
`endif
            end else begin
               err_nx   = 1'b1;
               state_nx = ERROR;
`ifdef KEY_LOADER_LOCKOUT_EN
               if (fail != FAIL_MAX) fail_nx = fail + FAIL_W'(1);
               if (fail_nx == FAIL_MAX) state_nx = LOCKOUT;
`endif
            end
         end
         LOCKED: state_nx = LOCKED;
         ERROR:  state_nx = ERROR;
`ifdef KEY_LOADER_LOCKOUT_EN
         LOCKOUT: state_nx = LOCKOUT;
`endif
         default: state_nx = IDLE;
      endcase

      if (clr_eff) begin
         state_nx = IDLE;
         sr_nx    = '0;
         cnt_nx   = '0;
         k_nx     = '0;
         ready_nx = 1'b0;
         err_nx   = 1'b0;
      end
   end

   // state and output registers, synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         sr        <= '0;
         cnt       <= '0;
         k         <= '0;
         key_ready <= 1'b0;
         key_err   <= 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
         fail      <= '0;
`endif
      end else begin
         state     <= state_nx;
         sr        <= sr_nx;
         cnt       <= cnt_nx;
         k         <= k_nx;
         key_ready <= ready_nx;
         key_err   <= err_nx;
`ifdef KEY_LOADER_LOCKOUT_EN
         fail      <= fail_nx;
`endif
      end
   end

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed scenarios plus randomized loads
// compared against a transaction-level model of the loader.
module tb_key_loader;

   localparam int unsigned KW = 14;
   localparam int unsigned CW = 4;
   localparam int unsigned MF = 3;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          sdi = 1'b0;
   logic          sdi_valid = 1'b0;
   logic          clr = 1'b0;
   logic [0:KW-1] k;
   logic          key_ready;
   logic          key_err;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   // model state: committed key, flags, fail count, lockout
   logic [0:KW-1] m_k = '0;
   bit            m_ready = 0;
   bit            m_err = 0;
   int            m_fail = 0;
   bit            m_lock = 0;

   key_loader #(.KEY_W(KW), .CHK_W(CW), .MAX_FAIL(MF)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .sdi       (sdi),
      .sdi_valid (sdi_valid),
      .clr       (clr),
      .k         (k),
      .key_ready (key_ready),
      .key_err   (key_err),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // parity of each checksum bin, counted directly from the definition
   function automatic logic [0:CW-1] ref_fold(input logic [0:KW-1] key);
      logic [0:CW-1] r;
      for (int j = 0; j < CW; j++) begin
         int ones = 0;
         for (int i = 0; i < KW; i++) if ((i % CW) == j && key[i]) ones++;
         r[j] = (ones % 2) == 1;
      end
      return r;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, "_k"}, 32'(k), 32'(m_k));
      check_val({tag, "_rdy"}, 32'(key_ready), 32'(m_ready));
      check_val({tag, "_err"}, 32'(key_err), 32'(m_err));
   endtask

   task automatic model_reset();
      m_k = '0; m_ready = 0; m_err = 0; m_fail = 0; m_lock = 0;
   endtask

   task automatic model_clr();
      if (!m_lock) begin
         m_k = '0; m_ready = 0; m_err = 0;
      end
   endtask

   task automatic model_commit(input logic [0:KW-1] key, input logic [0:CW-1] chk);
      if (ref_fold(key) == chk) begin
         m_k = key; m_ready = 1; m_err = 0; m_fail = 0;
      end else begin
         m_k = '0; m_ready = 0; m_err = 1;
`ifdef KEY_LOADER_LOCKOUT_EN
         if (m_fail < int'(MF)) m_fail++;
         if (m_fail == int'(MF)) m_lock = 1;
`endif
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      model_reset();
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
      model_clr();
   endtask

   task automatic drive_bit(input logic b);
      sdi = b;
      sdi_valid = 1'b1;
      step();
      sdi_valid = 1'b0;
      sdi = 1'b0;
   endtask

   // gap_mode: 0 back-to-back, 1 three idle cycles after every 2nd bit, 2 random gaps
   task automatic run_load(input logic [0:KW-1] key, input logic [0:CW-1] chk,
                           input int gap_mode, input string tag);
      bit active;
      active = !(m_ready || m_err || m_lock);
      for (int i = 0; i < int'(KW + CW); i++) begin
         drive_bit(i < int'(KW) ? key[i] : chk[i - int'(KW)]);
         if (active && i == 0) check_val({tag, "_busy0"}, 32'(busy), 32'(1));
         if (i != int'(KW + CW) - 1) begin
            if (gap_mode == 1 && (i % 2) == 1) begin
               repeat (3) step();
               if (active) check_val({tag, "_busygap"}, 32'(busy), 32'(1));
            end else if (gap_mode == 2) begin
               repeat ($urandom_range(0, 2)) step();
            end
         end
      end
      if (active) begin
         check_val({tag, "_chkbusy"}, 32'(busy), 32'(1));
         check_val({tag, "_chkrdy"}, 32'(key_ready), 32'(0));
         step();
         model_commit(key, chk);
      end else begin
         step();
      end
      check_outputs(tag);
      check_val({tag, "_busy"}, 32'(busy), 32'(0));
   endtask

   logic [0:KW-1] key1;
   logic [0:KW-1] key2;
   logic [0:CW-1] good1;
   logic [0:CW-1] bad1;
   logic [31:0]   spec_k;

   initial begin
      key1   = 14'b00110011000100;
      good1  = 4'b0001;
      bad1   = 4'b0000;
      spec_k = 32'h0CC4;
      key2   = 14'b10100101110010;

      // reset state
      do_reset();
      check_outputs("rst");
      check_val("rst_busy", 32'(busy), 32'(0));

      // valid load, fixed expected value
      run_load(key1, good1, 0, "t1");
      check_val("t1_kconst", 32'(k), spec_k);

      // bad checksum, ignored stream in ERROR, clr recovers
      pulse_clr();
      run_load(key1, bad1, 0, "t2");
      run_load(key1, good1, 0, "t2_ign");
      pulse_clr();
      check_outputs("t2_clr");

      // gapped stream
      run_load(key1, good1, 1, "t3");
      check_val("t3_kconst", 32'(k), spec_k);

      // partial load aborted by clr, then a fresh key
      pulse_clr();
      for (int i = 0; i < 9; i++) drive_bit(key1[i]);
      pulse_clr();
      check_val("t4_abort_busy", 32'(busy), 32'(0));
      check_outputs("t4_abort");
      run_load(key2, ref_fold(key2), 0, "t4");

      // clr and sdi_valid together: bit dropped
      pulse_clr();
      clr = 1'b1; sdi = 1'b1; sdi_valid = 1'b1;
      step();
      clr = 1'b0; sdi = 1'b0; sdi_valid = 1'b0;
      model_clr();
      check_val("t4_clrsdi_busy", 32'(busy), 32'(0));
      run_load(key1, good1, 0, "t4b");

      // clr during CHECK aborts the commit
      pulse_clr();
      for (int i = 0; i < int'(KW + CW); i++)
         drive_bit(i < int'(KW) ? key2[i] : ref_fold(key2)[i - int'(KW)]);
      pulse_clr();
      check_outputs("t4_clrchk");

      // LOCKED ignores sdi_valid; RST clears k
      run_load(key1, good1, 0, "t5");
      run_load(key2, ref_fold(key2), 0, "t5_ign");
      RST = 1'b1;
      step();
      RST = 1'b0;
      model_reset();
      check_outputs("t5_rst");

`ifdef KEY_LOADER_LOCKOUT_EN
      // three bad loads lock the loader until RST
      do_reset();
      for (int n = 0; n < int'(MF); n++) begin
         if (n != 0) pulse_clr();
         run_load(key1, bad1, 0, $sformatf("lo%0d", n));
      end
      pulse_clr();
      check_outputs("lo_clr");
      run_load(key1, good1, 0, "lo_ign");
      do_reset();
      run_load(key1, good1, 0, "lo_rst");
`endif

      // randomized loads against the model
      for (int it = 0; it < 24; it++) begin
         logic [0:KW-1] rk;
         logic [0:CW-1] rc;
         if (m_lock) do_reset();
         else if (m_ready || m_err) pulse_clr();
         rk = KW'($urandom);
         rc = ref_fold(rk);
         if ($urandom_range(0, 3) == 0) rc = rc ^ CW'($urandom_range(1, (1 << CW) - 1));
         if ($urandom_range(0, 4) == 0) begin
            int nb = $urandom_range(1, int'(KW + CW) - 1);
            for (int i = 0; i < nb; i++) drive_bit(rk[i % int'(KW)]);
            pulse_clr();
            check_outputs($sformatf("r%0d_abort", it));
         end
         run_load(rk, rc, $urandom_range(0, 2), $sformatf("r%0d", it));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
